spi_pixel_cmd_ctrl: RTL and testbench

- Command sequencer between the SPI byte receiver and the NeoPixel output path.
- Consumes the received byte stream (8-bit data plus a one-cycle ready strobe) and parses framed commands.
- Writes 24-bit GRB words into the pixel buffer RAM, bulk-fills it, and triggers the serial pixel driver while respecting its busy handshake.

---
 rtl/spi_pixel_cmd_ctrl_if.sv | 29 ++
 rtl/spi_pixel_cmd_ctrl.sv | 159 +++++++++++++++
 tb/tb_spi_pixel_cmd_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pixel_cmd_ctrl_if.sv
// Purpose : bundles the byte-stream input, driver handshake and pixel-buffer
//           write port of the SPI pixel command sequencer.
// Ports   : master = controller side (drives wr_*, show_start, err);
//           slave  = surrounding system (drives frame/rx/busy/err_clr).
// Latency : n/a (signal bundle only). Backpressure: n/a.
interface spi_pixel_cmd_ctrl_if #(
   parameter int ADDR_W = 6
);
   logic              frame_active;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              drv_busy;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [23:0]       wr_data;
   logic              show_start;
   logic              err;
   logic              err_clr;

   modport master (
      input  frame_active, rx_data, rx_ready, drv_busy, err_clr,
      output wr_en, wr_addr, wr_data, show_start, err
   );

   modport slave (
      output frame_active, rx_data, rx_ready, drv_busy, err_clr,
      input  wr_en, wr_addr, wr_data, show_start, err
   );
endinterface

// File: rtl/spi_pixel_cmd_ctrl.sv
// Purpose : parses framed SPI commands (WRITE/SHOW/FILL) into pixel-buffer
//           writes and a pixel-driver start pulse; sticky err on bad input.
// Latency : write one cycle after the B byte strobe; FILL takes NUM_PIXELS
//           cycles; show_start combinational once drv_busy is low.
// Backpr. : no rx backpressure - bytes arriving during FILL/SHOW_WAIT are
//           dropped and flag err; SHOW waits on drv_busy.
// Ports   : clk, rst_n (async active-low), bus (master modport).
module spi_pixel_cmd_ctrl #(
   parameter int NUM_PIXELS = 64,
   parameter int ADDR_W     = 6
) (
   input logic                   clk,
   input logic                   rst_n,
   spi_pixel_cmd_ctrl_if.master  bus
);

   typedef enum logic [3:0] {
      IDLE, W_IDX, W_CNT, W_G, W_R, W_B, F_G, F_R, F_B, FILL, SHOW_WAIT, DISCARD
   } state_t;

   state_t            state, state_d;
   // Pointer is one bit wider than a byte so it can run past 255 without wrapping.
   logic [8:0]        ptr, ptr_d;
   logic [7:0]        cnt, cnt_d;
   logic [7:0]        g, g_d, r, r_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [23:0]       wr_data_q, wr_data_d;
   logic              err_q, err_d, err_set;
   logic              rx_ok;

   // Bytes outside a frame are ignored entirely.
   assign rx_ok = bus.rx_ready & bus.frame_active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         g         <= '0;
         r         <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_d;
         ptr       <= ptr_d;
         cnt       <= cnt_d;
         g         <= g_d;
         r         <= r_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state;
      ptr_d     = ptr;
      cnt_d     = cnt;
      g_d       = g;
      r_d       = r;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_set   = 1'b0;

      case (state)
         IDLE: begin
            if (rx_ok) begin
               case (bus.rx_data)
                  8'h01:   state_d = W_IDX;
                  8'h02:   state_d = SHOW_WAIT;
                  8'h03:   state_d = F_G;
                  default: begin
                     err_set = 1'b1;
                     state_d = DISCARD;
                  end
               endcase
            end
         end
         W_IDX: if (rx_ok) begin
            ptr_d   = {1'b0, bus.rx_data};
            state_d = W_CNT;
         end
         W_CNT: if (rx_ok) begin
            cnt_d   = bus.rx_data;
            state_d = (bus.rx_data == 8'd0) ? IDLE : W_G;
         end
         W_G: if (rx_ok) begin
            g_d     = bus.rx_data;
            state_d = W_R;
         end
         W_R: if (rx_ok) begin
            r_d     = bus.rx_data;
            state_d = W_B;
         end
         W_B: if (rx_ok) begin
            // Out-of-range pixels are skipped but still consume a count slot.
            if (ptr < 9'(NUM_PIXELS)) begin
               wr_en_d   = 1'b1;
               wr_addr_d = ptr[ADDR_W-1:0];
               wr_data_d = {g, r, bus.rx_data};
            end else begin
               err_set = 1'b1;
            end
            ptr_d   = ptr + 9'd1;
            cnt_d   = cnt - 8'd1;
            state_d = (cnt == 8'd1) ? IDLE : W_G;
         end
         F_G: if (rx_ok) begin
            g_d     = bus.rx_data;
            state_d = F_R;
         end
         F_R: if (rx_ok) begin
            r_d     = bus.rx_data;
            state_d = F_B;
         end
         F_B: if (rx_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = {g, r, bus.rx_data};
            state_d   = FILL;
         end
         FILL: begin
            // wr_addr doubles as the fill counter; the write on the bus
            // this cycle is the one at wr_addr_q.
            if (rx_ok) err_set = 1'b1;
            if (wr_addr_q == ADDR_W'(NUM_PIXELS - 1)) begin
               state_d = IDLE;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = wr_addr_q + 1'b1;
            end
         end
         SHOW_WAIT: begin
            if (rx_ok) err_set = 1'b1;
            if (!bus.drv_busy) state_d = IDLE;
         end
         DISCARD: ;
         default: state_d = IDLE;
      endcase

      // Frame end abandons parsing, but FILL and SHOW_WAIT run to completion.
      if (!bus.frame_active && state != FILL && state != SHOW_WAIT) state_d = IDLE;

      // A new error in the same cycle as err_clr leaves err set.
      err_d = (err_q & ~bus.err_clr) | err_set;
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.err        = err_q;
   assign bus.show_start = (state == SHOW_WAIT) && !bus.drv_busy;

endmodule

// File: tb/tb_spi_pixel_cmd_ctrl.sv
// Purpose : self-checking bench for spi_pixel_cmd_ctrl; a frame-level model
//           queues expected writes/show pulses, a monitor pops and compares.
// Latency : n/a. Backpressure: n/a.
module tb_spi_pixel_cmd_ctrl;
   localparam int NUM_PIXELS = 64;
   localparam int ADDR_W     = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_pixel_cmd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   spi_pixel_cmd_ctrl #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   bit          mon_en = 1'b1;
   bit          exp_err = 1'b0;
   logic [31:0] exp_wr_q[$];
   int          exp_show_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_write(input int a, input logic [23:0] d);
      exp_wr_q.push_back((32'(a) << 24) | 32'(d));
   endtask

   task automatic run_monitor;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (bus.wr_en) begin
               if (exp_wr_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_write: got addr %0d data 0x%06h, expected none (cycle %0d)",
                           bus.wr_addr, bus.wr_data, cyc);
               end else begin
                  logic [31:0] e;
                  e = exp_wr_q.pop_front();
                  check("write", (32'(bus.wr_addr) << 24) | 32'(bus.wr_data), e);
               end
            end
            if (bus.show_start) begin
               if (exp_show_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_show: got pulse at cycle %0d, expected none", cyc);
               end else begin
                  int e;
                  e = exp_show_q.pop_front();
                  check("show_cycle", 32'(cyc), 32'(e));
                  check("show_busy_low", 32'(bus.drv_busy), 32'd0);
               end
            end
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.rx_data  = b;
      bus.rx_ready = 1'b1;
      tick(1);
      bus.rx_ready = 1'b0;
      tick(gap);
   endtask

   function automatic int rgap();
      return int'($urandom_range(0, 2));
   endfunction

   function automatic logic [7:0] rbyte();
      return 8'($urandom_range(0, 255));
   endfunction

   task automatic frame_begin;
      bus.frame_active = 1'b1;
      tick(1);
   endtask

   task automatic frame_end;
      bus.frame_active = 1'b0;
      tick(2);
   endtask

   task automatic pulse_clr;
      bus.err_clr = 1'b1;
      tick(1);
      bus.err_clr = 1'b0;
   endtask

   // SHOW command; drv_busy stays high for n cycles after the strobe.
   task automatic send_show(input int n);
      bus.drv_busy = (n > 0);
      bus.rx_data  = 8'h02;
      bus.rx_ready = 1'b1;
      tick(1);
      bus.rx_ready = 1'b0;
      tick(n);
      bus.drv_busy = 1'b0;
      exp_show_q.push_back(cyc);
      tick(1);
   endtask

   // WRITE command with model; partial drops the frame before the last B byte.
   task automatic do_write(input int idx, input int cnt, input bit partial);
      logic [7:0] gb, rb, bb;
      send_byte(8'h01, rgap());
      send_byte(8'(idx), rgap());
      send_byte(8'(cnt), rgap());
      for (int k = 0; k < cnt; k++) begin
         gb = rbyte(); rb = rbyte(); bb = rbyte();
         send_byte(gb, rgap());
         send_byte(rb, rgap());
         if (partial && k == cnt - 1) return;
         if (idx + k < NUM_PIXELS) exp_write(idx + k, {gb, rb, bb});
         else exp_err = 1'b1;
         send_byte(bb, rgap());
      end
   endtask

   task automatic do_fill(input logic [7:0] gb, input logic [7:0] rb, input logic [7:0] bb);
      send_byte(8'h03, rgap());
      send_byte(gb, rgap());
      send_byte(rb, rgap());
      for (int a = 0; a < NUM_PIXELS; a++) exp_write(a, {gb, rb, bb});
      send_byte(bb, NUM_PIXELS + 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.frame_active = 1'b0;
      bus.rx_data      = 8'h00;
      bus.rx_ready     = 1'b0;
      bus.drv_busy     = 1'b0;
      bus.err_clr      = 1'b0;
      fork
         run_monitor();
      join_none

      // Reset state
      tick(3);
      check("rst_wr_en", 32'(bus.wr_en), 0);
      check("rst_wr_addr", 32'(bus.wr_addr), 0);
      check("rst_wr_data", 32'(bus.wr_data), 0);
      check("rst_show", 32'(bus.show_start), 0);
      check("rst_err", 32'(bus.err), 0);
      rst_n = 1'b1;
      tick(2);

      // Two-pixel WRITE
      exp_write(5, 24'h102030);
      exp_write(6, 24'h405060);
      frame_begin();
      send_byte(8'h01, 0); send_byte(8'h05, 1); send_byte(8'h02, 0);
      send_byte(8'h10, 0); send_byte(8'h20, 2); send_byte(8'h30, 0);
      send_byte(8'h40, 1); send_byte(8'h50, 0); send_byte(8'h60, 2);
      frame_end();
      check("write_err", 32'(bus.err), 0);
      check("write_pending", 32'(exp_wr_q.size()), 0);

      // FILL with a byte injected mid-fill, together with err_clr
      frame_begin();
      send_byte(8'h03, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
      for (int a = 0; a < NUM_PIXELS; a++) exp_write(a, 24'hAABBCC);
      send_byte(8'hCC, 10);
      bus.err_clr = 1'b1;
      send_byte(8'h55, 0);
      bus.err_clr = 1'b0;
      check("fill_inject_err", 32'(bus.err), 1);
      tick(NUM_PIXELS);
      frame_end();
      check("fill_pending", 32'(exp_wr_q.size()), 0);
      check("fill_err_sticky", 32'(bus.err), 1);
      pulse_clr();
      check("fill_err_clr", 32'(bus.err), 0);

      // SHOW with a busy driver, then with an idle one
      frame_begin();
      send_show(10);
      frame_end();
      frame_begin();
      send_show(0);
      frame_end();
      check("show_pending", 32'(exp_show_q.size()), 0);
      check("show_err", 32'(bus.err), 0);

      // Bounds: second pixel beyond the buffer
      exp_write(63, 24'h112233);
      frame_begin();
      send_byte(8'h01, 0); send_byte(8'h3F, 0); send_byte(8'h02, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
      send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
      frame_end();
      check("bounds_err", 32'(bus.err), 1);
      check("bounds_pending", 32'(exp_wr_q.size()), 0);
      pulse_clr();
      check("bounds_err_clr", 32'(bus.err), 0);

      // Bad command discards the rest of the frame
      frame_begin();
      send_byte(8'h7E, 0); send_byte(8'h01, 0); send_byte(8'h05, 0);
      send_byte(8'h01, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      frame_end();
      check("badcmd_err", 32'(bus.err), 1);
      exp_write(0, 24'h112233);
      frame_begin();
      send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
      frame_end();
      check("badcmd_next_pending", 32'(exp_wr_q.size()), 0);
      check("badcmd_err_sticky", 32'(bus.err), 1);
      pulse_clr();

      // Frame dropped mid-pixel
      frame_begin();
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h01, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0);
      frame_end();
      check("drop_err", 32'(bus.err), 0);
      check("drop_pending", 32'(exp_wr_q.size()), 0);

      // Reset in the middle of a FILL
      mon_en = 1'b0;
      frame_begin();
      send_byte(8'h03, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
      send_byte(8'h56, 10);
      check("rstfill_running", 32'(bus.wr_en), 1);
      bus.frame_active = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rstfill_wr_en", 32'(bus.wr_en), 0);
      check("rstfill_wr_addr", 32'(bus.wr_addr), 0);
      check("rstfill_wr_data", 32'(bus.wr_data), 0);
      check("rstfill_show", 32'(bus.show_start), 0);
      check("rstfill_err", 32'(bus.err), 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      mon_en = 1'b1;
      tick(4);

      // Randomised frames against the frame-level model
      for (int f = 0; f < 40; f++) begin
         int  ncmd;
         bit  done;
         pulse_clr();
         exp_err = 1'b0;
         done    = 1'b0;
         ncmd    = int'($urandom_range(1, 3));
         frame_begin();
         for (int k = 0; k < ncmd; k++) begin
            if (!done) begin
               int kind;
               kind = int'($urandom_range(0, 9));
               if (kind < 5) begin
                  bit part;
                  part = (k == ncmd - 1) && ($urandom_range(0, 3) == 0);
                  do_write(int'($urandom_range(0, 70)),
                           part ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3)), part);
                  if (part) done = 1'b1;
               end else if (kind < 7) begin
                  do_fill(rbyte(), rbyte(), rbyte());
               end else if (kind < 9) begin
                  send_show(int'($urandom_range(0, 5)));
               end else begin
                  int bad;
                  bad = int'($urandom_range(4, 256));
                  send_byte((bad == 256) ? 8'h00 : 8'(bad), rgap());
                  send_byte(rbyte(), rgap());
                  send_byte(rbyte(), rgap());
                  exp_err = 1'b1;
                  done    = 1'b1;
               end
            end
         end
         frame_end();
         check("rand_err", 32'(bus.err), 32'(exp_err));
      end

      tick(5);
      check("final_wr_queue", 32'(exp_wr_q.size()), 0);
      check("final_show_queue", 32'(exp_show_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
